cpu_ctrl_seq: RTL and testbench

- Multi-cycle control sequencer for the 16-bit processor core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives every load/enable/select of the datapath (PC, IR, register file, ALU, dout register).
- Handshakes with the shared memory port via req/ready; halts on HALT opcode until reset.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/cpu_op_decode.sv | 42 ++++
 rtl/cpu_ctrl_seq.sv | 174 +++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : opcode, state, ALU and writeback encodings for the core    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_LDI   = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_BZ    = 4'h9;
    localparam logic [3:0] OP_IN    = 4'hA;
    localparam logic [3:0] OP_OUT   = 4'hB;
    localparam logic [3:0] OP_ILL_C = 4'hC;
    localparam logic [3:0] OP_ILL_D = 4'hD;
    localparam logic [3:0] OP_ILL_E = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4
    } alu_op_t;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;
    localparam logic [1:0] WB_DIN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cpu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_op_decode : opcode to instruction-class bits and ALU operation   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cpu_op_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_halt,
    output logic       is_illegal,
    output logic [2:0] alu_op
);

    always_comb begin
        is_alu     = 1'b0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_PASS;
        case (opcode)
            OP_ADD: begin is_alu = 1'b1; alu_op = ALU_ADD; end
            OP_SUB: begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_AND: begin is_alu = 1'b1; alu_op = ALU_AND; end
            OP_OR:  begin is_alu = 1'b1; alu_op = ALU_OR;  end
            OP_LD:  is_mem = 1'b1;
            OP_ST:  begin is_mem = 1'b1; is_store = 1'b1; end
            OP_JMP, OP_BZ: is_branch = 1'b1;
            OP_HALT: is_halt = 1'b1;
            OP_ILL_C, OP_ILL_D, OP_ILL_E: is_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl_seq : multi-cycle fetch/decode/exec/mem/wb control FSM      |
// | Option ILLEGAL_TRAP_EN: opcodes C-E trap to HALT and raise illegal_op |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int ALUW     = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [15:0]     instr,
    input  logic            zero_flag,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic [ALUW-1:0] alu_op,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic            out_load,
    output logic            halted,
    output logic            wait_err,
    output logic [2:0]      state_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic            illegal_op
`endif
);

    localparam int CNTW = $clog2(WAIT_MAX + 1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] wait_cnt_q, wait_cnt_d;
    logic            wait_err_q, wait_err_d;
    logic            illegal_q, illegal_d;

    logic [OPW-1:0]  w_opcode;
    logic            w_is_alu, w_is_mem, w_is_store, w_is_branch;
    logic            w_is_halt, w_is_illegal;
    logic [2:0]      w_dec_alu_op;
    logic            w_waiting;
    logic            w_unused_instr;

    assign w_opcode       = instr[15 -: OPW];
    assign w_unused_instr = ^instr[15-OPW:0];

    cpu_op_decode u_dec (
        .opcode     (w_opcode),
        .is_alu     (w_is_alu),
        .is_mem     (w_is_mem),
        .is_store   (w_is_store),
        .is_branch  (w_is_branch),
        .is_halt    (w_is_halt),
        .is_illegal (w_is_illegal),
        .alu_op     (w_dec_alu_op)
    );

    // Strobes are decoded from the registered state, so async reset clears them at once.
    always_comb begin
        state_d  = state_q;
        illegal_d = illegal_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        alu_op   = '0;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        out_load = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_START: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (w_is_alu) begin
                    alu_op = ALUW'(w_dec_alu_op);
                    rf_we  = 1'b1;
                    wb_sel = WB_ALU;
                end else if (w_opcode == OP_LDI) begin
                    rf_we  = 1'b1;
                    wb_sel = WB_IMM;
                end else if (w_is_mem) begin
                    state_d = ST_MEM;
                end else if (w_is_branch) begin
                    pc_load = (w_opcode == OP_JMP) ? 1'b1 : zero_flag;
                end else if (w_opcode == OP_IN) begin
                    rf_we  = 1'b1;
                    wb_sel = WB_DIN;
                end else if (w_opcode == OP_OUT) begin
                    out_load = 1'b1;
                end else if (w_is_halt) begin
                    state_d = ST_HALT;
                end else if (w_is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
`else
                    state_d   = ST_FETCH;
`endif
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = w_is_store;
                if (mem_ready) begin
                    state_d = w_is_store ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                wb_sel  = WB_MEM;
                state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_START;
        endcase
    end

    // The error flag rises on the edge where the counter reaches WAIT_MAX.
    always_comb begin
        w_waiting  = mem_req && !mem_ready;
        wait_cnt_d = '0;
        wait_err_d = wait_err_q;
        if (w_waiting) begin
            wait_cnt_d = (wait_cnt_q == CNTW'(WAIT_MAX)) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_q == CNTW'(WAIT_MAX - 1)) begin
                wait_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_START;
            wait_cnt_q <= '0;
            wait_err_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wait_err_q <= wait_err_d;
            illegal_q  <= illegal_d;
        end
    end

    assign wait_err = wait_err_q;
    assign state_o  = state_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_ctrl_seq : directed self-checking bench for cpu_ctrl_seq      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cpu_ctrl_seq;

    logic        clock, reset;
    logic [15:0] instr;
    logic        zero_flag, mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic [2:0]  alu_op;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        out_load, halted, wait_err;
    logic [2:0]  state_o;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    cpu_ctrl_seq #(.OPW(4), .ALUW(3), .WAIT_MAX(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .instr      (instr),
        .zero_flag  (zero_flag),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .alu_op     (alu_op),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .out_load   (out_load),
        .halted     (halted),
        .wait_err   (wait_err),
        .state_o    (state_o)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    // {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_op, rf_we, wb_sel, out_load, halted}
    logic [13:0] w_strb;
    assign w_strb = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
                     alu_op, rf_we, wb_sel, out_load, halted};

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Called while in FETCH with mem_ready=1; leaves the FSM in EXEC.
    task automatic fetch_to_exec(input logic [15:0] ins, input string tag);
        check_eq({tag, " fetch"}, 16'(state_o), 16'd1);
        instr = ins;
        tick;
        check_eq({tag, " decode"}, 16'(state_o), 16'd2);
        check_eq({tag, " decode strobes"}, 16'(w_strb), 16'h0000);
        tick;
        check_eq({tag, " exec"}, 16'(state_o), 16'd3);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_eq({tag, " rst strobes"}, 16'(w_strb), 16'h0000);
        check_eq({tag, " rst state"}, 16'(state_o), 16'd0);
        check_eq({tag, " rst wait_err"}, 16'(wait_err), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq({tag, " start"}, 16'(state_o), 16'd0);
        tick;
        check_eq({tag, " to fetch"}, 16'(state_o), 16'd1);
    endtask

    initial begin
        reset     = 1'b1;
        instr     = 16'h0000;
        zero_flag = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("reset state", 16'(state_o), 16'd0);
        check_eq("reset strobes", 16'(w_strb), 16'h0000);
        check_eq("reset wait_err", 16'(wait_err), 16'd0);
        #14;
        reset = 1'b0;
        #1;
        check_eq("start state", 16'(state_o), 16'd0);
        check_eq("start strobes", 16'(w_strb), 16'h0000);
        tick;
        check_eq("fetch state", 16'(state_o), 16'd1);
        check_eq("fetch mem_req", 16'(mem_req), 16'd1);
        check_eq("fetch addr_sel", 16'(addr_sel), 16'd0);
        check_eq("fetch ir_load", 16'(ir_load), 16'd1);
        check_eq("fetch pc_inc", 16'(pc_inc), 16'd1);

        fetch_to_exec(16'h1234, "add");
        check_eq("add alu_op", 16'(alu_op), 16'd1);
        check_eq("add rf_we", 16'(rf_we), 16'd1);
        check_eq("add wb_sel", 16'(wb_sel), 16'd0);
        check_eq("add mem_req", 16'(mem_req), 16'd0);
        tick;
        check_eq("add back to fetch", 16'(state_o), 16'd1);

        fetch_to_exec(16'h6010, "ld");
        check_eq("ld exec strobes", 16'(w_strb), 16'h0000);
        mem_ready = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            check_eq("ld mem wait state", 16'(state_o), 16'd4);
            check_eq("ld mem req/sel/we", 16'({mem_req, addr_sel, mem_we}), 16'b110);
            tick;
        end
        mem_ready = 1'b1;
        #1;
        check_eq("ld mem 4th cycle", 16'(state_o), 16'd4);
        check_eq("ld mem 4th rf_we", 16'(rf_we), 16'd0);
        tick;
        check_eq("ld wb state", 16'(state_o), 16'd5);
        check_eq("ld wb rf_we", 16'(rf_we), 16'd1);
        check_eq("ld wb wb_sel", 16'(wb_sel), 16'd1);
        check_eq("ld wb mem_req", 16'(mem_req), 16'd0);
        check_eq("ld wait_err", 16'(wait_err), 16'd0);
        tick;
        check_eq("ld after wb rf_we", 16'(rf_we), 16'd0);

        zero_flag = 1'b1;
        fetch_to_exec(16'h9055, "bz taken");
        check_eq("bz taken pc_load", 16'(pc_load), 16'd1);
        tick;
        zero_flag = 1'b0;
        fetch_to_exec(16'h9055, "bz not taken");
        check_eq("bz not taken pc_load", 16'(pc_load), 16'd0);
        tick;

        fetch_to_exec(16'h8042, "jmp");
        check_eq("jmp pc_load", 16'(pc_load), 16'd1);
        tick;
        fetch_to_exec(16'h5abc, "ldi");
        check_eq("ldi rf_we/wb_sel", 16'({rf_we, wb_sel}), 16'b110);
        tick;
        fetch_to_exec(16'hA000, "in");
        check_eq("in rf_we/wb_sel", 16'({rf_we, wb_sel}), 16'b111);
        tick;
        fetch_to_exec(16'hB000, "out");
        check_eq("out out_load/rf_we", 16'({out_load, rf_we}), 16'b10);
        tick;
        fetch_to_exec(16'h2000, "sub");
        check_eq("sub alu_op", 16'(alu_op), 16'd2);
        tick;
        fetch_to_exec(16'h4000, "or");
        check_eq("or alu_op", 16'(alu_op), 16'd4);
        tick;
        fetch_to_exec(16'h0000, "nop");
        check_eq("nop strobes", 16'(w_strb), 16'h0000);
        tick;

        fetch_to_exec(16'h7011, "st");
        tick;
        check_eq("st mem state", 16'(state_o), 16'd4);
        check_eq("st mem req/sel/we", 16'({mem_req, addr_sel, mem_we}), 16'b111);
        tick;
        check_eq("st back to fetch", 16'(state_o), 16'd1);

        mem_ready = 1'b0;
        #1;
        check_eq("wait ir_load", 16'(ir_load), 16'd0);
        check_eq("wait mem_req", 16'(mem_req), 16'd1);
        repeat (14) tick;
        check_eq("wait_err after 14", 16'(wait_err), 16'd0);
        tick;
        check_eq("wait_err after 15", 16'(wait_err), 16'd1);
        tick;
        check_eq("wait_err sticky", 16'(wait_err), 16'd1);
        check_eq("wait still fetch", 16'(state_o), 16'd1);
        mem_ready = 1'b1;
        #1;
        check_eq("wait ready ir_load", 16'(ir_load), 16'd1);
        #2;
        do_reset("midfetch");

`ifdef ILLEGAL_TRAP_EN
        fetch_to_exec(16'hC000, "illegal trap");
        check_eq("illegal_op before trap", 16'(illegal_op), 16'd0);
        tick;
        check_eq("illegal trap state", 16'(state_o), 16'd6);
        check_eq("illegal_op set", 16'(illegal_op), 16'd1);
        check_eq("illegal halted", 16'(halted), 16'd1);
        #2;
        do_reset("after trap");
`else
        fetch_to_exec(16'hC000, "illegal c");
        check_eq("illegal c strobes", 16'(w_strb), 16'h0000);
        tick;
        check_eq("illegal c to fetch", 16'(state_o), 16'd1);
        fetch_to_exec(16'hE000, "illegal e");
        tick;
        check_eq("illegal e to fetch", 16'(state_o), 16'd1);
`endif

        fetch_to_exec(16'hF000, "halt");
        tick;
        check_eq("halt state", 16'(state_o), 16'd6);
        check_eq("halt strobes", 16'(w_strb), 16'h0001);
        for (int i = 0; i < 5; i++) begin
            tick;
            check_eq("halt hold", 16'({state_o, mem_req, halted}), 16'({3'd6, 1'b0, 1'b1}));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
